// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: merges load-use, multi-cycle EX hold and flush into stall_o/flush_o, with mc_busy_o/mc_done_o status and a saturating stall_cnt_o
module pipe_stall_ctrl #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_reg1_read,
  input  logic [4:0]        id_reg1_addr,
  input  logic              id_reg2_read,
  input  logic [4:0]        id_reg2_addr,
  input  logic              ex_is_load,
  input  logic              ex_wreg,
  input  logic [4:0]        ex_waddr,
  input  logic              mc_start,
  input  logic [CNT_W-1:0]  mc_cycles,
  input  logic              flush_req,
  output logic [5:0]        stall_o,
  output logic              flush_o,
  output logic              mc_busy_o,
  output logic              mc_done_o,
  output logic [PERF_W-1:0] stall_cnt_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic ex_hold, load_use;
  always_comb begin
    ex_hold = (state == IDLE && mc_start && mc_cycles >= CNT_W'(2)) || state == BUSY;
    load_use = ex_is_load && ex_wreg && ex_waddr != 5'd0 &&
               ((id_reg1_read && id_reg1_addr == ex_waddr) || (id_reg2_read && id_reg2_addr == ex_waddr));
    stall_o = (rst || flush_req) ? 6'b000000 : ex_hold ? 6'b001111 : load_use ? 6'b000111 : 6'b000000;
    flush_o = flush_req && !rst;
    mc_busy_o = !rst && state == BUSY;
    mc_done_o = !rst && !flush_req && state == DONE;
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (flush_req) begin
      state_n = IDLE;
      cnt_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (mc_start && mc_cycles >= CNT_W'(3)) begin
            state_n = BUSY;
            cnt_n = mc_cycles - CNT_W'(2);
          end else if (mc_start && mc_cycles == CNT_W'(2)) begin
            state_n = DONE;
          end
        end
        BUSY: begin
          cnt_n = cnt - CNT_W'(1);
          state_n = (cnt == CNT_W'(1)) ? DONE : BUSY;
        end
        DONE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      stall_cnt_o <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (|stall_o && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + PERF_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: scoreboard bench, cycle-level reference model vs pipe_stall_ctrl
module tb_pipe_stall_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_reg1_read = 1'b0, id_reg2_read = 1'b0;
  logic [4:0] id_reg1_addr = '0, id_reg2_addr = '0, ex_waddr = '0;
  logic ex_is_load = 1'b0, ex_wreg = 1'b0, mc_start = 1'b0, flush_req = 1'b0;
  logic [5:0] mc_cycles = '0;
  logic [5:0] stall_o;
  logic flush_o, mc_busy_o, mc_done_o;
  logic [31:0] stall_cnt_o;

  pipe_stall_ctrl #(.CNT_W(6), .PERF_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_reg1_read(id_reg1_read), .id_reg1_addr(id_reg1_addr),
    .id_reg2_read(id_reg2_read), .id_reg2_addr(id_reg2_addr),
    .ex_is_load(ex_is_load), .ex_wreg(ex_wreg), .ex_waddr(ex_waddr),
    .mc_start(mc_start), .mc_cycles(mc_cycles), .flush_req(flush_req),
    .stall_o(stall_o), .flush_o(flush_o), .mc_busy_o(mc_busy_o),
    .mc_done_o(mc_done_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    logic [5:0] stall;
    logic flush, busy, done;
    logic [31:0] perf;
  } exp_t;
  exp_t sb[$];

  int passed = 0, total = 0;

  // reference model: an issued op occupies EX from cycle iss to iss+n-1,
  // held for all but the last of those cycles
  bit op_active = 0;
  longint cyc = 0, iss = 0, n = 0;
  longint perf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".stall"}, 32'(stall_o), 32'(e.stall));
      chk({e.tag, ".flush"}, 32'(flush_o), 32'(e.flush));
      chk({e.tag, ".busy"}, 32'(mc_busy_o), 32'(e.busy));
      chk({e.tag, ".done"}, 32'(mc_done_o), 32'(e.done));
      chk({e.tag, ".perf"}, stall_cnt_o, e.perf);
    end
  end

  task automatic step(input string tag);
    exp_t e;
    bit lu, hold, issue, done, busy;
    longint last;
    lu = ex_is_load && ex_wreg && ex_waddr != 0 &&
         ((id_reg1_read && id_reg1_addr == ex_waddr) || (id_reg2_read && id_reg2_addr == ex_waddr));
    last = iss + n - 1;
    issue = 0;
    done = 0;
    busy = 0;
    if (op_active) begin
      hold = cyc < last;
      done = cyc == last && !flush_req;
      busy = cyc > iss && cyc < last;
    end else begin
      hold = mc_start && mc_cycles >= 2;
      issue = hold && !flush_req;
    end
    e.tag = tag;
    e.stall = (rst || flush_req) ? 6'd0 : hold ? 6'b001111 : lu ? 6'b000111 : 6'd0;
    e.flush = flush_req && !rst;
    e.busy = busy && !rst;
    e.done = done && !rst;
    e.perf = 32'(perf);
    sb.push_back(e);
    if (rst) begin
      op_active = 0;
      perf = 0;
    end else begin
      if (e.stall != 0 && perf < 64'hFFFF_FFFF) perf++;
      if (flush_req || (op_active && cyc >= last)) op_active = 0;
      else if (issue) begin
        op_active = 1;
        iss = cyc;
        n = mc_cycles;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in;
    {id_reg1_read, id_reg2_read, ex_is_load, ex_wreg, mc_start, flush_req} = '0;
    {id_reg1_addr, id_reg2_addr, ex_waddr, mc_cycles} = '0;
  endtask

  task automatic set_lu(input logic [4:0] wa);
    ex_is_load = 1; ex_wreg = 1; ex_waddr = wa;
    id_reg1_read = 1; id_reg1_addr = 5'd5;
  endtask

  initial begin
    @(posedge clk);
    #1;
    repeat (2) step("reset");
    rst = 0;
    step("idle");
    set_lu(5'd5);
    step("load_use");
    set_lu(5'd0);
    id_reg1_addr = 5'd0;
    step("load_use_r0");
    clear_in();
    mc_start = 1; mc_cycles = 6'd4;
    step("mc4_issue");
    mc_start = 0;
    repeat (4) step("mc4_run");
    mc_start = 1; mc_cycles = 6'd2;
    step("mc2_issue");
    mc_start = 0;
    repeat (2) step("mc2_run");
    mc_start = 1; mc_cycles = 6'd1;
    step("mc1");
    mc_cycles = 6'd0;
    step("mc0");
    mc_cycles = 6'd6;
    step("prio_issue");
    mc_start = 0;
    set_lu(5'd5);
    step("prio_busy_lu");
    flush_req = 1;
    step("prio_flush");
    clear_in();
    repeat (2) step("post_flush");
    mc_start = 1; mc_cycles = 6'd5;
    step("rst_issue");
    mc_start = 0;
    rst = 1;
    step("rst_mid");
    mc_start = 1; set_lu(5'd5); flush_req = 1;
    step("rst_forced");
    clear_in();
    rst = 0;
    repeat (2) step("post_rst");
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(99) == 0);
      flush_req = ($urandom_range(19) == 0);
      mc_start = ($urandom_range(5) == 0);
      mc_cycles = 6'($urandom_range(7));
      ex_is_load = $urandom_range(1);
      ex_wreg = $urandom_range(1);
      ex_waddr = 5'($urandom_range(3));
      id_reg1_read = $urandom_range(1);
      id_reg1_addr = 5'($urandom_range(3));
      id_reg2_read = $urandom_range(1);
      id_reg2_addr = 5'($urandom_range(3));
      step("random");
    end
    clear_in();
    rst = 0;
    repeat (8) step("drain");
    force dut.stall_cnt_o = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_o;
    perf = 64'hFFFF_FFFE;
    set_lu(5'd5);
    repeat (3) step("sat");
    clear_in();
    repeat (2) step("sat_hold");
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      total++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
